// File: rtl/i2c_pkg.sv
// Shared encodings for the I2C bit engine: command ops, FSM states and
// the default quarter-period divider.
package i2c_pkg;

  localparam int unsigned QDIV_DEFAULT = 250;

  typedef enum logic [1:0] {
    OP_NONE  = 2'b00,
    OP_WRITE = 2'b01,
    OP_READ  = 2'b10,
    OP_RSVD  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BIT,
    ST_STOP,
    ST_DONE
  } state_e;

  function automatic logic is_xfer(op_e op);
    return (op == OP_WRITE) || (op == OP_READ);
  endfunction

  // Shared by accept and end-of-START: byte first, then STOP, else finish.
  function automatic state_e next_after_start(op_e op, logic stop);
    if (is_xfer(op)) return ST_BIT;
    if (stop)        return ST_STOP;
    return ST_DONE;
  endfunction

endpackage

// File: rtl/i2c_bit_engine_if.sv
// Command/response channel between the upstream I2C controller FSM and
// the bit engine.
interface i2c_bit_engine_if;
  import i2c_pkg::*;

  logic       cmd_valid;
  logic       cmd_ready;
  op_e        cmd_op;
  logic       cmd_start;
  logic       cmd_stop;
  logic [7:0] cmd_tx_byte;
  logic       cmd_rd_nack;
  logic       done;
  logic [7:0] rx_byte;
  logic       ack_n;
  logic       busy;

  modport master (
    output cmd_valid, cmd_op, cmd_start, cmd_stop, cmd_tx_byte, cmd_rd_nack,
    input  cmd_ready, done, rx_byte, ack_n, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_start, cmd_stop, cmd_tx_byte, cmd_rd_nack,
    output cmd_ready, done, rx_byte, ack_n, busy
  );

endinterface

// File: rtl/i2c_qtick.sv
// Quarter-period tick generator; the count is pinned at 0 while cleared,
// disabled or held (SCL stretched by a slave).
module i2c_qtick #(
  parameter int unsigned QDIV = 250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  input  logic i_hold,
  output logic o_tick
);

  localparam int unsigned CW = (QDIV > 1) ? $clog2(QDIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(QDIV - 1);

  logic [CW-1:0] r_cnt;

  assign o_tick = i_en && !i_hold && !i_clr && (r_cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr || i_hold || !i_en) begin
      r_cnt <= '0;
    end else if (r_cnt == LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2c_bit_engine.sv
// I2C master bit engine: one command = optional START, optional 9-bit byte
// (WRITE or READ), optional STOP. Pads are open-drain (oe = 1 pulls low).
//
// state | meaning
// IDLE  | waiting for command; SCL parked low if last command had no STOP
// START | P0 rel SDA, P1 rel SCL, P2 SDA low, P3 SCL low
// BIT   | 9 bits: P0 SCL low + set SDA, P1 rel SCL, P2 sample, P3 SCL low
// STOP  | P0 both low, P1 rel SCL, P2 rel SDA, P3 bus idle
// DONE  | one-cycle completion pulse
module i2c_bit_engine
  import i2c_pkg::*;
#(
  parameter int unsigned QDIV = QDIV_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  i2c_bit_engine_if.slave cmd,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        scl_oe,
  output logic        sda_oe
);

  state_e     r_state, w_state_nxt;
  logic [1:0] r_phase, w_phase_nxt;
  logic [3:0] r_bit,   w_bit_nxt;

  op_e        r_op;
  logic       r_stop;
  logic       r_nack;
  logic       r_scl_park;
  logic [7:0] r_tx;
  logic [7:0] r_shift;
  logic [7:0] r_rx_byte;
  logic       r_ack_n;

  logic       w_busy;
  logic       w_accept;
  logic       w_tick;
  logic       w_hold;
  logic       w_last_phase;
  logic       w_bit_drive;
  logic       w_scl_oe;
  logic       w_sda_oe;

  assign w_busy       = (r_state != ST_IDLE);
  assign w_accept     = cmd.cmd_valid && !w_busy;
  assign w_last_phase = w_tick && (r_phase == 2'd3);
  // Released SCL still read low means a slave is stretching: freeze the phase.
  assign w_hold       = !w_scl_oe && !scl_i &&
                        (r_state inside {ST_START, ST_BIT, ST_STOP});

  i2c_qtick #(.QDIV(QDIV)) u_qtick (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_clr  (w_accept),
    .i_en   (w_busy),
    .i_hold (w_hold),
    .o_tick (w_tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_phase <= 2'd0;
      r_bit   <= 4'd0;
    end else begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_bit   <= w_bit_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_bit_nxt   = r_bit;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_phase_nxt = 2'd0;
          w_bit_nxt   = 4'd0;
          w_state_nxt = cmd.cmd_start ? ST_START
                                      : next_after_start(cmd.cmd_op, cmd.cmd_stop);
        end
      end
      ST_START: begin
        if (w_tick) begin
          w_phase_nxt = r_phase + 2'd1;
          if (r_phase == 2'd3) w_state_nxt = next_after_start(r_op, r_stop);
        end
      end
      ST_BIT: begin
        if (w_tick) begin
          w_phase_nxt = r_phase + 2'd1;
          if (r_phase == 2'd3) begin
            if (r_bit == 4'd8) w_state_nxt = r_stop ? ST_STOP : ST_DONE;
            else               w_bit_nxt   = r_bit + 4'd1;
          end
        end
      end
      ST_STOP: begin
        if (w_tick) begin
          w_phase_nxt = r_phase + 2'd1;
          if (r_phase == 2'd3) w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_bit_drive = (r_bit == 4'd8) ? ((r_op == OP_READ)  && !r_nack)
                                  : ((r_op == OP_WRITE) && !r_tx[7]);
    w_scl_oe = r_scl_park;
    w_sda_oe = 1'b0;
    case (r_state)
      ST_START: begin
        case (r_phase)
          2'd0:    begin w_scl_oe = r_scl_park; w_sda_oe = 1'b0; end
          2'd1:    begin w_scl_oe = 1'b0;       w_sda_oe = 1'b0; end
          2'd2:    begin w_scl_oe = 1'b0;       w_sda_oe = 1'b1; end
          default: begin w_scl_oe = 1'b1;       w_sda_oe = 1'b1; end
        endcase
      end
      ST_BIT: begin
        w_scl_oe = (r_phase == 2'd0) || (r_phase == 2'd3);
        w_sda_oe = w_bit_drive;
      end
      ST_STOP: begin
        case (r_phase)
          2'd0:    begin w_scl_oe = 1'b1; w_sda_oe = 1'b1; end
          2'd1:    begin w_scl_oe = 1'b0; w_sda_oe = 1'b1; end
          default: begin w_scl_oe = 1'b0; w_sda_oe = 1'b0; end
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op       <= OP_NONE;
      r_stop     <= 1'b0;
      r_nack     <= 1'b0;
      r_scl_park <= 1'b0;
      r_tx       <= 8'h00;
      r_shift    <= 8'h00;
      r_rx_byte  <= 8'h00;
      r_ack_n    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_op   <= cmd.cmd_op;
        r_stop <= cmd.cmd_stop;
        r_nack <= cmd.cmd_rd_nack;
        r_tx   <= cmd.cmd_tx_byte;
      end
      // Sample at the end of P2, after SCL has been high for a full quarter.
      if ((r_state == ST_BIT) && w_tick && (r_phase == 2'd2)) begin
        if (r_bit != 4'd8) begin
          if (r_op == OP_READ) r_shift <= {r_shift[6:0], sda_i};
        end else begin
          if (r_op == OP_WRITE) r_ack_n   <= sda_i;
          if (r_op == OP_READ)  r_rx_byte <= r_shift;
        end
      end
      if ((r_state == ST_BIT) && w_last_phase) r_tx <= {r_tx[6:0], 1'b0};
      if (w_last_phase && ((r_state == ST_START) || (r_state == ST_BIT)))
        r_scl_park <= 1'b1;
      if (w_last_phase && (r_state == ST_STOP))
        r_scl_park <= 1'b0;
    end
  end

  assign scl_oe        = w_scl_oe;
  assign sda_oe        = w_sda_oe;
  assign cmd.cmd_ready = !w_busy;
  assign cmd.busy      = w_busy;
  assign cmd.done      = (r_state == ST_DONE);
  assign cmd.rx_byte   = r_rx_byte;
  assign cmd.ack_n     = r_ack_n;

endmodule

// File: tb/tb_i2c_bit_engine.sv
// Bench for i2c_bit_engine: open-drain pull-up model, small slave model
// with bus monitor, and an expected-result queue checked on every done.
module tb_i2c_bit_engine;
  import i2c_pkg::*;

  localparam int QDIV   = 4;
  localparam int BUDGET = 3000;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  i2c_bit_engine_if bus();

  logic scl_oe, sda_oe, scl_i, sda_i;
  logic slv_scl_low = 1'b0;
  logic slv_sda_low = 1'b0;
  assign scl_i = !(scl_oe || slv_scl_low);
  assign sda_i = !(sda_oe || slv_sda_low);

  i2c_bit_engine #(.QDIV(QDIV)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .cmd    (bus),
    .scl_i  (scl_i),
    .sda_i  (sda_i),
    .scl_oe (scl_oe),
    .sda_oe (sda_oe)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // slave model: 0 absent, 1 ACKs a written byte, 2 sends slv_data
  int         slv_mode        = 0;
  logic [7:0] slv_data        = 8'h00;
  int         slv_stretch_bit = -1;
  int         stretch_left    = 0;

  logic       prev_scl   = 1'b1;
  logic       prev_sda   = 1'b1;
  int         bitcnt     = 0;
  logic [7:0] mon_byte   = 8'h00;
  logic       mon_ack    = 1'b0;
  int         mon_starts = 0;
  int         mon_stops  = 0;
  int         hi_cnt     = 0;
  int         lo_cnt     = 0;
  int         hi_time [10];
  int         lo_time [10];

  always @(posedge clk) begin
    prev_scl <= scl_i;
    prev_sda <= sda_i;
    if (scl_i) hi_cnt <= prev_scl ? hi_cnt + 1 : 1;
    else       lo_cnt <= prev_scl ? 1 : lo_cnt + 1;
    if (prev_scl && scl_i && prev_sda && !sda_i) begin
      mon_starts <= mon_starts + 1;
      bitcnt     <= 0;
    end
    if (prev_scl && scl_i && !prev_sda && sda_i) mon_stops <= mon_stops + 1;
    if (!prev_scl && scl_i) begin
      if (bitcnt < 8)       mon_byte <= {mon_byte[6:0], sda_i};
      else if (bitcnt == 8) mon_ack  <= sda_i;
      if (bitcnt < 10) lo_time[bitcnt] <= lo_cnt;
      bitcnt <= bitcnt + 1;
    end
    if (prev_scl && !scl_i) begin
      if (bitcnt >= 1 && bitcnt <= 9) hi_time[bitcnt-1] <= hi_cnt;
      if (slv_mode == 2 && bitcnt < 8)       slv_sda_low <= !slv_data[7-bitcnt];
      else if (slv_mode == 1 && bitcnt == 8) slv_sda_low <= 1'b1;
      else                                   slv_sda_low <= 1'b0;
      if (bitcnt == slv_stretch_bit) begin
        slv_scl_low  <= 1'b1;
        stretch_left <= 20;
      end
    end else if (stretch_left > 0) begin
      stretch_left <= stretch_left - 1;
      if (stretch_left == 1) slv_scl_low <= 1'b0;
    end
  end

  typedef struct {
    int         kind;      // 0 write, 1 read, 2 no byte
    bit         has_stop;
    logic [7:0] exp_byte;
    logic       exp_ack;
    int         exp_starts;
    int         exp_stops;
  } sb_t;

  sb_t sb_q[$];
  int  exp_starts_tot = 0;
  int  exp_stops_tot  = 0;
  int  done_count     = 0;

  task automatic push_exp(input int kind, input bit st, input bit sp,
                          input logic [7:0] b, input logic ack);
    sb_t e;
    exp_starts_tot += int'(st);
    exp_stops_tot  += int'(sp);
    e.kind = kind; e.has_stop = sp; e.exp_byte = b; e.exp_ack = ack;
    e.exp_starts = exp_starts_tot; e.exp_stops = exp_stops_tot;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      chk("sb_pending", 32'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        sb_t e;
        e = sb_q.pop_front();
        done_count <= done_count + 1;
        if (e.kind == 0) begin
          chk("ack_n",       32'(bus.ack_n), 32'(e.exp_ack));
          chk("wr_bus_byte", 32'(mon_byte),  32'(e.exp_byte));
          chk("wr_bus_ack",  32'(mon_ack),   32'(e.exp_ack));
        end else if (e.kind == 1) begin
          chk("rx_byte",     32'(bus.rx_byte), 32'(e.exp_byte));
          chk("rd_bus_byte", 32'(mon_byte),    32'(e.exp_byte));
          chk("rd_bus_ack",  32'(mon_ack),     32'(e.exp_ack));
        end
        if (e.kind != 2) chk("scl_pulses", 32'(bitcnt), 32'(9 + int'(e.has_stop)));
        chk("starts",      32'(mon_starts), 32'(e.exp_starts));
        chk("stops",       32'(mon_stops),  32'(e.exp_stops));
        chk("scl_oe_done", 32'(scl_oe),     32'(!e.has_stop));
        chk("sda_oe_done", 32'(sda_oe),     0);
      end
    end
  end

  task automatic send(input op_e op, input logic st, input logic sp,
                      input logic [7:0] tx, input logic nk);
    int n;
    @(negedge clk);
    bus.cmd_op = op; bus.cmd_start = st; bus.cmd_stop = sp;
    bus.cmd_tx_byte = tx; bus.cmd_rd_nack = nk; bus.cmd_valid = 1'b1;
    n = 0;
    while (!bus.cmd_ready && n < BUDGET) begin @(negedge clk); n++; end
    chk("accept_wait", 32'(n < BUDGET), 1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!bus.done && n < BUDGET) begin @(negedge clk); n++; end
    chk("done_wait", 32'(n < BUDGET), 1);
  endtask

  task automatic chk_reset_state(input string pfx);
    chk({pfx, "_scl_oe"},  32'(scl_oe),        0);
    chk({pfx, "_sda_oe"},  32'(sda_oe),        0);
    chk({pfx, "_ready"},   32'(bus.cmd_ready), 1);
    chk({pfx, "_busy"},    32'(bus.busy),      0);
    chk({pfx, "_done"},    32'(bus.done),      0);
    chk({pfx, "_rx_byte"}, 32'(bus.rx_byte),   0);
    chk({pfx, "_ack_n"},   32'(bus.ack_n),     0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int dc;
    logic prev_done;
    bus.cmd_valid = 1'b0; bus.cmd_op = OP_NONE; bus.cmd_start = 1'b0;
    bus.cmd_stop = 1'b0; bus.cmd_tx_byte = 8'h00; bus.cmd_rd_nack = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_state("rst");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // START + WRITE 0x7C, ACK, no STOP: SCL stays parked low
    slv_mode = 1;
    push_exp(0, 1, 0, 8'h7C, 1'b0);
    send(OP_WRITE, 1'b1, 1'b0, 8'h7C, 1'b0);
    wait_done();
    @(negedge clk);
    chk("done_pulse_width", 32'(bus.done), 0);
    repeat (10) @(negedge clk);
    chk("scl_parked", 32'(scl_oe), 1);
    chk("sda_released", 32'(sda_oe), 0);

    // repeated START + READ 0xA5, master NACK, STOP
    slv_mode = 2; slv_data = 8'hA5;
    push_exp(1, 1, 1, 8'hA5, 1'b1);
    send(OP_READ, 1'b1, 1'b1, 8'h00, 1'b1);
    wait_done();
    repeat (5) @(negedge clk);

    // clock stretch of 20 cycles at the start of bit 3
    slv_mode = 1; slv_stretch_bit = 3;
    push_exp(0, 1, 1, 8'h3C, 1'b0);
    send(OP_WRITE, 1'b1, 1'b1, 8'h3C, 1'b0);
    wait_done();
    chk("hi_bit2", 32'(hi_time[2]), 32'(2*QDIV));
    chk("hi_bit3_stretched", 32'(hi_time[3]), 32'(2*QDIV));
    chk("lo_bit3_stretched", 32'(lo_time[3] >= 20), 1);
    slv_stretch_bit = -1;
    repeat (5) @(negedge clk);

    // WRITE to absent slave: NACK, STOP still issued, single done
    slv_mode = 0;
    dc = done_count;
    push_exp(0, 1, 1, 8'hA0, 1'b1);
    send(OP_WRITE, 1'b1, 1'b1, 8'hA0, 1'b0);
    wait_done();
    repeat (30) @(negedge clk);
    chk("done_once", 32'(done_count - dc), 1);

    // reset in the middle of a byte, then a normal transfer
    slv_mode = 1;
    push_exp(0, 1, 1, 8'h55, 1'b0);
    send(OP_WRITE, 1'b1, 1'b1, 8'h55, 1'b0);
    n = 0;
    while (bitcnt != 5 && n < BUDGET) begin @(negedge clk); n++; end
    chk("bit5_wait", 32'(n < BUDGET), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_state("midrst");
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    exp_starts_tot = mon_starts;
    exp_stops_tot  = mon_stops;
    push_exp(0, 1, 1, 8'h7C, 1'b0);
    send(OP_WRITE, 1'b1, 1'b1, 8'h7C, 1'b0);
    wait_done();
    repeat (5) @(negedge clk);

    // second command held on cmd_valid while busy; accepted only once idle
    push_exp(0, 1, 0, 8'h96, 1'b0);
    @(negedge clk);
    bus.cmd_op = OP_WRITE; bus.cmd_start = 1'b1; bus.cmd_stop = 1'b0;
    bus.cmd_tx_byte = 8'h96; bus.cmd_rd_nack = 1'b0; bus.cmd_valid = 1'b1;
    @(negedge clk);
    chk("first_accepted", 32'(bus.busy), 1);
    bus.cmd_op = OP_NONE; bus.cmd_start = 1'b0; bus.cmd_stop = 1'b1;
    push_exp(2, 0, 1, 8'h00, 1'b0);
    n = 0; prev_done = 1'b0;
    while (!bus.cmd_ready && n < BUDGET) begin
      prev_done = bus.done;
      @(negedge clk);
      n++;
    end
    chk("held_wait", 32'(n < BUDGET), 1);
    chk("ready_after_done", 32'(prev_done), 1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("accepted_on_ready", 32'(bus.busy), 1);
    wait_done();
    repeat (5) @(negedge clk);
    chk("final_scl_oe", 32'(scl_oe), 0);
    chk("sb_drained", 32'(sb_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/i2c_bit_engine.md
I2C_BIT_ENGINE -- requirements
Module: i2c_bit_engine

Interface
REQ-001 Parameter QDIV, default 250, SHALL set clock cycles per SCL quarter-period (100 MHz CLK -> 100 kHz SCL); legal range 2..65535.
REQ-002 CLK  in  1  sole clock; all state changes on rising edge.
REQ-003 RST_N  in  1  reset, asynchronous assert, active-low.
REQ-004 cmd_valid  in  1  command request from upstream FMC I2C controller FSM.
REQ-005 cmd_ready  out  1  engine idle, command accepted when cmd_valid&&cmd_ready.
REQ-006 cmd_op  in  2  00 NONE, 01 WRITE, 10 READ, 11 reserved (treated as NONE).
REQ-007 cmd_start  in  1  issue START (or repeated START) before byte.
REQ-008 cmd_stop  in  1  issue STOP after byte.
REQ-009 cmd_tx_byte  in  8  byte for WRITE, MSB first.
REQ-010 cmd_rd_nack  in  1  READ only: master drives NACK (1) or ACK (0) in 9th bit.
REQ-011 done  out  1  one-cycle pulse at command completion.
REQ-012 rx_byte  out  8  byte received by READ.
REQ-013 ack_n  out  1  WRITE: SDA sampled in 9th bit (1 = slave NACK).
REQ-014 busy  out  1  command in progress (= !cmd_ready).
REQ-015 scl_i, sda_i  in  1 each  pad input values from IOBUF.
REQ-016 scl_oe, sda_oe  out  1 each  1 = drive pad low, 0 = release (IOBUF T = !oe, I = 0).

Function
REQ-017 Quarter tick SHALL pulse once every QDIV cycles while busy; counter reset to 0 on accept.
REQ-018 States SHALL be IDLE, START, BIT, STOP, DONE; each of START/BIT/STOP spans 4 quarter phases P0..P3.
REQ-019 Accept: IDLE -> START if cmd_start, else BIT if op WRITE/READ, else STOP if cmd_stop, else DONE; command fields latched at accept.
REQ-020 START: P0 release SDA, P1 release SCL, P2 drive SDA low, P3 drive SCL low; then BIT/STOP/DONE per same priority.
REQ-021 BIT (9 bits): P0 SCL low, set sda_oe = !data bit; P1 release SCL; P2 sample sda_i; P3 drive SCL low.
REQ-022 WRITE bits 0..7 drive cmd_tx_byte[7-i]; bit 8 releases SDA, samples ack_n.
REQ-023 READ bits 0..7 release SDA, shift sda_i into rx_byte LSB; bit 8 drives sda_oe = !cmd_rd_nack.
REQ-024 Clock stretching: in any phase following SCL release, the quarter counter SHALL hold at 0 while scl_i == 0; no timeout.
REQ-025 STOP: P0 drive SDA and SCL low, P1 release SCL, P2 release SDA, P3 idle; then DONE.
REQ-026 DONE lasts one cycle: done = 1, then IDLE; rx_byte/ack_n held until next accept.
REQ-027 After STOP both oe = 0; after command without STOP, SCL held low (scl_oe = 1) until next command.
REQ-028 Slave NACK on WRITE SHALL NOT abort; requested STOP still issued.
REQ-029 cmd_valid while busy SHALL be ignored (cmd_ready = 0); upstream holds it.

Reset
REQ-030 RST_N low SHALL immediately force scl_oe = 0, sda_oe = 0, cmd_ready = 1, busy = 0, done = 0, rx_byte = 0, ack_n = 0, state IDLE, counters 0, including mid-byte.

Structure
REQ-031 Package i2c_pkg SHALL hold op encoding enum, state enum, and default QDIV constant.
REQ-032 One sub-module i2c_qtick (parameterised quarter-tick counter with hold input) is natural; the FSM stays in i2c_bit_engine.

Verification (QDIV = 4, open-drain pull-up model, I2C slave BFM)
REQ-033 START+WRITE 0x7C, slave ACKs -> SDA falls while SCL high, bits 0,1,1,1,1,1,0,0 on SCL rises, done after 9 SCL pulses, ack_n = 0, SCL held low.
REQ-034 READ with stop, cmd_rd_nack = 1, slave sends 0xA5 -> rx_byte = 0xA5, SDA released in 9th bit, STOP (SDA rises while SCL high), both oe = 0.
REQ-035 WRITE with stop to absent slave -> ack_n = 1, STOP still issued, done pulse exactly once.
REQ-036 Slave holds SCL low 20 cycles in bit 3 -> phase counter frozen, high-time of that bit still 2 quarters after scl_i rises, data intact.
REQ-037 RST_N asserted at bit 5 of WRITE -> scl_oe = sda_oe = 0 same cycle, cmd_ready = 1; next START+WRITE completes normally.
REQ-038 cmd_valid held during busy with different op -> ignored until done, then accepted on cycle cmd_ready = 1.
